// File: rtl/ibex_register_file_mp.sv
// Multi-port integer register file: N read / M write ports, optional
// write-through bypass, pending-write scoreboard and write-conflict flag.
module ibex_register_file_mp #(
    parameter bit          RV32E        = 1'b0,
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned NrReadPorts  = 2,
    parameter int unsigned NrWritePorts = 2,
    parameter bit          WriteThrough = 1'b0
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NrReadPorts*5-1:0]          raddr_i,
    output logic [NrReadPorts*DataWidth-1:0]  rdata_o,
    output logic [NrReadPorts-1:0]            rbusy_o,
    input  logic [NrWritePorts*5-1:0]         waddr_i,
    input  logic [NrWritePorts*DataWidth-1:0] wdata_i,
    input  logic [NrWritePorts-1:0]           we_i,
    input  logic                              reserve_i,
    input  logic [4:0]                        reserve_addr_i,
    output logic [31:0]                       busy_o,
    output logic                              wconflict_o
);

    localparam int unsigned AW = RV32E ? 4 : 5;
    localparam int unsigned NW = 1 << AW;

    logic [DataWidth-1:0] r_rf [NW];
    logic [NW-1:0]        r_busy;
    logic                 r_wconf;

    logic [DataWidth-1:0] w_wval [NW];
    logic [NW-1:0]        w_wen;
    logic [NW-1:0]        w_busy_nxt;
    logic                 w_conf;
    logic                 w_rsv;

    function automatic logic f_legal(input logic [4:0] a);
        return (a != 5'd0) && !(RV32E && a[4]);
    endfunction

    // Ascending port order: later ports overwrite, so the highest index wins.
    always_comb begin
        w_wen = '0;
        for (int a = 0; a < NW; a++) begin
            w_wval[a] = '0;
        end
        for (int m = 0; m < NrWritePorts; m++) begin
            if (we_i[m] && f_legal(waddr_i[5*m +: 5])) begin
                w_wen[waddr_i[5*m +: AW]]  = 1'b1;
                w_wval[waddr_i[5*m +: AW]] = wdata_i[DataWidth*m +: DataWidth];
            end
        end
    end

    always_comb begin
        w_conf = 1'b0;
        for (int i = 0; i < NrWritePorts; i++) begin
            for (int j = i + 1; j < NrWritePorts; j++) begin
                if (we_i[i] && we_i[j] && f_legal(waddr_i[5*i +: 5]) &&
                    (waddr_i[5*i +: 5] == waddr_i[5*j +: 5])) begin
                    w_conf = 1'b1;
                end
            end
        end
    end

    assign w_rsv = reserve_i && f_legal(reserve_addr_i);

    // A reserve in the same cycle as a write names a newer producer: set wins.
    always_comb begin
        w_busy_nxt = '0;
        for (int a = 1; a < NW; a++) begin
            if (w_rsv && (reserve_addr_i[AW-1:0] == AW'(a))) begin
                w_busy_nxt[a] = 1'b1;
            end else if (w_wen[a]) begin
                w_busy_nxt[a] = 1'b0;
            end else begin
                w_busy_nxt[a] = r_busy[a];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int a = 0; a < NW; a++) begin
                r_rf[a] <= '0;
            end
            r_busy  <= '0;
            r_wconf <= 1'b0;
        end else begin
            for (int a = 0; a < NW; a++) begin
                if (w_wen[a]) begin
                    r_rf[a] <= w_wval[a];
                end
            end
            r_busy  <= w_busy_nxt;
            r_wconf <= w_conf;
        end
    end

    always_comb begin
        rdata_o = '0;
        rbusy_o = '0;
        for (int p = 0; p < NrReadPorts; p++) begin
            if (f_legal(raddr_i[5*p +: 5])) begin
                if (WriteThrough && w_wen[raddr_i[5*p +: AW]]) begin
                    rdata_o[DataWidth*p +: DataWidth] = w_wval[raddr_i[5*p +: AW]];
                end else begin
                    rdata_o[DataWidth*p +: DataWidth] = r_rf[raddr_i[5*p +: AW]];
                end
                if (WriteThrough) begin
                    rbusy_o[p] = w_busy_nxt[raddr_i[5*p +: AW]];
                end else begin
                    rbusy_o[p] = r_busy[raddr_i[5*p +: AW]];
                end
            end
        end
    end

    always_comb begin
        busy_o = '0;
        busy_o[NW-1:0] = r_busy;
    end

    assign wconflict_o = r_wconf;

endmodule
